// File: rtl/full_adder_pkg.sv
// Shared constants and result type for the ripple-carry full adder.
package full_adder_pkg;

   localparam int FA_DEFAULT_WIDTH = 1;

   typedef struct packed {
      logic                        cout;
      logic [FA_DEFAULT_WIDTH-1:0] s;
   } fa_result_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full-adder cell; chained by full_adder to form a ripple-carry adder.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic p;

   assign p    = a ^ b;
   assign s    = p ^ cin;
   assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder of WIDTH full_adder_cell instances with optional output
// register, enabled by defining FULL_ADDER_REG_OUT_EN.
module full_adder
   import full_adder_pkg::*;
#(
   parameter int WIDTH = FA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic [WIDTH-1:0] s_q,
   output logic             cout_q
);

   logic [WIDTH:0] k;

   assign k[0] = c;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_cell u_cell (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (k[i]),
         .s    (s[i]),
         .cout (k[i+1])
      );
   end

   assign cout = k[WIDTH];

`ifdef FULL_ADDER_REG_OUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         s_q    <= s;
         cout_q <= cout;
      end
   end
`else
   // Unregistered build: clk and reset are kept on the port list but unused.
   logic unused_clk_reset;

   assign unused_clk_reset = clk | reset;
   assign s_q              = s;
   assign cout_q           = cout;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder (WIDTH=1 and WIDTH=8 instances), using a
// scoreboard of expected {cout, s} values; covers both FULL_ADDER_REG_OUT_EN builds.
module tb_full_adder;
   import full_adder_pkg::*;

   logic       clk = 1'b0;
   logic       clk_run = 1'b1;
   logic       reset;
   logic       a1, b1, c1, s1, co1, sq1, coq1;
   logic [7:0] a8, b8, s8, sq8;
   logic       c8, co8, coq8;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string      tag;
      logic [8:0] exp;
   } sb_t;

   sb_t sb[$];

   always #5 if (clk_run) clk = ~clk;

   full_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .reset(reset), .a(a1), .b(b1), .c(c1),
      .s(s1), .cout(co1), .s_q(sq1), .cout_q(coq1)
   );

   full_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .a(a8), .b(b8), .c(c8),
      .s(s8), .cout(co8), .s_q(sq8), .cout_q(coq8)
   );

   task automatic push(input string tag, input logic [8:0] exp);
      sb_t e;
      e.tag = tag;
      e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic check(input logic [8:0] obs);
      sb_t e;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL scoreboard_empty observed=%h", obs);
         return;
      end
      e = sb.pop_front();
      assert (obs === e.exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
   endtask

   function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y,
                                           input logic ci);
      return {1'b0, x} + {1'b0, y} + {8'b0, ci};
   endfunction

   initial begin
      logic [2:0] v;
      reset = 1'b1;
      {a1, b1, c1} = 3'b000;
      a8 = '0; b8 = '0; c8 = 1'b0;
      #1;

      // Exhaustive WIDTH=1 truth table; reset is held high with clocks running.
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         {a1, b1, c1} = v;
         push($sformatf("comb_w1_%03b", v), {7'b0, 2'(v[2]) + 2'(v[1]) + 2'(v[0])});
`ifdef FULL_ADDER_REG_OUT_EN
         push($sformatf("reg_in_reset_%03b", v), 9'h000);
`else
         push($sformatf("passthru_w1_%03b", v), {7'b0, 2'(v[2]) + 2'(v[1]) + 2'(v[0])});
`endif
         #5;
         check({7'b0, co1, s1});
         check({7'b0, coq1, sq1});
         #5;
      end

      // WIDTH=8 carry ripple, complementary patterns, then a few random operands.
      for (int i = 0; i < 6; i++) begin
         case (i)
            0:       begin a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; end
            1:       begin a8 = 8'hA5; b8 = 8'h5A; c8 = 1'b0; end
            2:       begin a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; end
            default: begin
               a8 = 8'($urandom_range(0, 255));
               b8 = 8'($urandom_range(0, 255));
               c8 = 1'($urandom_range(0, 1));
            end
         endcase
         push($sformatf("comb_w8_%0d", i), ref_add8(a8, b8, c8));
         #5;
         check({co8, s8});
         #5;
      end

`ifdef FULL_ADDER_REG_OUT_EN
      // Latency: release reset, capture 000, then apply 011 before edge N.
      @(negedge clk);
      reset = 1'b0;
      {a1, b1, c1} = 3'b000;
      @(negedge clk);
      {a1, b1, c1} = 3'b011;
      push("reg_before_edge", 9'h000);
      #1;
      check({7'b0, coq1, sq1});
      @(posedge clk);
      #1;
      push("reg_after_edge", 9'h002);
      check({7'b0, coq1, sq1});
      @(posedge clk);
      #1;
      push("reg_w8_capture", ref_add8(a8, b8, c8));
      check({coq8, sq8});

      // Asynchronous reset between edges.
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      push("async_reset_w1", 9'h000);
      check({7'b0, coq1, sq1});
      push("async_reset_w8", 9'h000);
      check({coq8, sq8});
      push("comb_during_reset", 9'h002);
      check({7'b0, co1, s1});
`else
      // Unregistered build: outputs follow inputs with the clock stopped.
      clk_run = 1'b0;
      #3;
      reset = 1'b0;
      {a1, b1, c1} = 3'b101;
      #1;
      push("passthru_idle_clk", 9'h002);
      check({7'b0, coq1, sq1});
      push("comb_idle_clk", 9'h002);
      check({7'b0, co1, s1});
      a8 = 8'h3C; b8 = 8'hC4; c8 = 1'b0;
      #1;
      push("passthru_w8", 9'h100);
      check({coq8, sq8});
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/full_adder.md
# full_adder

Binary full adder for the datapath labs: adds two operands and a carry-in, producing a sum and carry-out. It is built as a ripple chain of 1-bit cells. The default configuration is the single-bit full adder. Sum and carry-out are available both combinationally and, optionally, as registered copies for pipelined datapaths.

## Interface
- Clocking: one clock; reset is asynchronous and active-high.
- Parameter `WIDTH`, default 1: operand width in bits; must be ≥ 1.
- Port `clk`, input, 1 bit: clock, rising edge.
- Port `reset`, input, 1 bit: asynchronous, active-high; clears the registered outputs only.
- Port `a`, input, WIDTH bits: operand A.
- Port `b`, input, WIDTH bits: operand B.
- Port `c`, input, 1 bit: carry-in.
- Port `s`, output, WIDTH bits: combinational sum.
- Port `cout`, output, 1 bit: combinational carry-out.
- Port `s_q`, output, WIDTH bits: registered sum.
- Port `cout_q`, output, 1 bit: registered carry-out.

## Operation
- Result: {cout, s} = a + b + c, computed at WIDTH+1 bits with no truncation of the carry.
- Cell i:
  - s[i] = a[i] ^ b[i] ^ k[i]
  - k[i+1] = (a[i] & b[i]) | (k[i] & (a[i] ^ b[i]))
  - k[0] = c; cout = k[WIDTH].
- WIDTH=1 truth table (s, cout):
  - 000→(0,0), 001→(1,0), 010→(1,0), 011→(0,1)
  - 100→(1,0), 101→(0,1), 110→(0,1), 111→(1,1)
- `s` and `cout` depend only on a, b, c. They are unaffected by `clk` and `reset`.
- X/Z on any input bit propagates to the dependent outputs; no masking.
- No state machine; the only state is the optional output register.

## Timing
- `s` and `cout`: zero-cycle combinational path from inputs. They must settle within one input-change interval, so a bench sampling 10 ns after an input change reads final values.
- `s_q` and `cout_q`, when registered:
  - Capture `s` and `cout` on each rising `clk`; latency is 1 cycle.
  - Reset value is 0 for both.
  - Asserting `reset` clears them immediately, without waiting for a clock edge.
  - While `reset` is high, they hold 0 even if clocks arrive.
  - First capture happens on the first rising edge after `reset` deasserts.
- If an input changes in the same delta as a clock edge, the register captures the pre-edge settled value (standard non-blocking semantics).

## Configuration
- Macro `FULL_ADDER_REG_OUT_EN`.
- Defined: `s_q` and `cout_q` are flip-flops as described under Timing.
- Undefined: no flops are inferred. `s_q` = `s` and `cout_q` = `cout` combinationally; `clk` and `reset` are unused. The port list is identical in both builds.

## Structure
- Package `full_adder_pkg` holds:
  - `FA_DEFAULT_WIDTH` = 1
  - typedef `fa_result_t`: packed struct {logic cout; logic [WIDTH-1:0] s;} at default width
- Sub-module `full_adder_cell`: a 1-bit cell with ports a, b, cin, s, cout, instantiated WIDTH times in a generate loop. The top level contains the carry chain and the optional output register.

## Test plan
- WIDTH=1, exhaustive stimulus: apply all 8 {a,b,c} combinations from 000 to 111, 10 ns apart → `s`/`cout` match the truth table in Operation at each step. In particular, 111 gives s=1, cout=1.
- Reset, macro defined: hold `reset`=1 while applying a=1, b=1, c=1 with clocks running → `s_q`=0, `cout_q`=0 throughout, while `s`=1 and `cout`=1.
- Latency, macro defined: deassert reset, then apply a=0, b=1, c=1 before edge N → `s_q`=0, `cout_q`=1 visible after edge N, not before.
- Asynchronous reset mid-operation: with `cout_q`=1, assert `reset` between clock edges → `s_q` and `cout_q` drop to 0 before the next edge.
- WIDTH=8 carry ripple: a=8'hFF, b=8'h00, c=1 → s=8'h00, cout=1. Then a=8'hA5, b=8'h5A, c=0 → s=8'hFF, cout=0.
- Macro undefined: apply a=1, b=0, c=1 with `clk` idle → `s_q`=0 and `cout_q`=1 immediately, equal to `s` and `cout`.
